display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Time-multiplexes the six BCD digits of the clock (HH:MM:SS) onto one seven-segment decoder.
- Sits directly upstream of the decoder. Its `digit_data` feeds the decoder's 4-bit `data` input. It drives the active-low digit anodes of the shared-segment display.
- Adds a per-slot dead time (anti-ghosting), frame-coherent snapshots, per-digit blink and leading-zero blanking.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (2..8).
- DWELL_CYCLES, 1000, clock cycles per digit slot, including dead time.
- DEAD_CYCLES, 16, cycles at the start of each slot with all anodes off. Must satisfy 1 <= DEAD_CYCLES < DWELL_CYCLES.
- BLINK_FRAMES, 32, frames per blink half-period (>= 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = scan active; 0 = display dark
- digits_in  in  4*NUM_DIGITS  BCD digits; digit i in bits [4i+3:4i]; digit 0 = seconds units, digit NUM_DIGITS-1 = hours tens
- blink_mask  in  NUM_DIGITS  bit i = 1 makes digit i blink
- lz_blank  in  1  1 = blank digit NUM_DIGITS-1 when its value is 0
- digit_data  out  4  BCD value of the current slot, to the decoder
- anode_n  out  NUM_DIGITS  active-low digit enables; at most one bit low at any time
- digit_index  out  3  current slot index
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - anode_n = all 1s
  - digit_data = 0, digit_index = 0, frame_start = 0
  - slot counter, frame counter, shadow register and blink_phase = 0
  - state = S_IDLE
- State machine S_IDLE / S_DEAD / S_ON; cnt counts 0..DWELL_CYCLES-1.
- S_IDLE:
  - anode_n all 1s.
  - When enable = 1, at the next edge:
    - shadow <= digits_in
    - digit_index <= 0, digit_data <= digits_in[3:0], cnt <= 0
    - frame_start <= 1
    - go to S_DEAD
- S_DEAD:
  - anode_n all 1s; cnt increments.
  - When cnt == DEAD_CYCLES-1, go to S_ON.
- S_ON:
  - anode_n[digit_index] = 0 unless suppressed; all other bits are 1.
  - When cnt == DWELL_CYCLES-1:
    - cnt <= 0
    - digit_index advances; digit_data <= shadow digit of the new index
    - go to S_DEAD
    - anode_n returns to all 1s on that same edge, so digit_data changes only while dark.
- Slot timing: each slot is DEAD_CYCLES dark cycles followed by DWELL_CYCLES-DEAD_CYCLES lit cycles. Frame length = NUM_DIGITS*DWELL_CYCLES cycles.
- Wrap: when advancing from index NUM_DIGITS-1, the index becomes 0 and at the same edge:
  - shadow <= digits_in
  - frame_start pulses for 1 cycle
  - frame counter increments; when it reaches BLINK_FRAMES it clears to 0 and blink_phase toggles.
- Snapshot: changes to digits_in mid-frame never appear before the next frame_start.
- Suppression (anode held at 1 for the whole slot; digit_data still shows the value). Any one of these suppresses digit i:
  - blink_mask[i] = 1 and blink_phase = 1
  - i == NUM_DIGITS-1, lz_blank = 1, and the shadow digit == 0
  - the shadow digit > 9 (the decoder table only covers 0..9)
- blink_mask and lz_blank are sampled live, not snapshotted.
- Dropping enable:
  - If enable = 0 in any state, the next state is S_IDLE and anode_n becomes all 1s at the next edge.
  - cnt and digit_index reset to 0 on entry to S_IDLE.
  - blink_phase and the frame counter hold their values.
- Reset mid-slot: all outputs return to reset values at the next edge regardless of state. Reset has priority over enable.

Test Plan (DWELL_CYCLES=8, DEAD_CYCLES=2, BLINK_FRAMES=2):
- Basic scan:
  - Stimulus: reset, then enable=1 with digits_in = 0x123456.
  - Expected: frame_start pulses once. digit_data runs 6,5,4,3,2,1. Each slot has anode_n = 6'b111111 for 2 cycles, then bit i low for 6 cycles. The next frame_start comes 48 cycles later.
- Snapshot:
  - Stimulus: set digits_in to 0x999999 in the middle of slot 2.
  - Expected: slots 2..5 still show 4,3,2,1. The next frame shows all 9s.
- Blink:
  - Stimulus: blink_mask = 6'b110000.
  - Expected: anode_n[5:4] stay 1 throughout frames 2-3. They are lit in frames 0-1 and 4-5. Digits 0-3 are lit in every frame.
- Leading zero:
  - Stimulus: digits_in = 0x052000.
  - Expected with lz_blank=1: anode_n[5] = 1 for all of slot 5, with digit_data = 0.
  - Expected with lz_blank=0: anode_n[5] is low for 6 cycles.
- Invalid BCD:
  - Stimulus: digit 2 = 4'hA.
  - Expected: digit_data = 4'hA during slot 2, and anode_n stays all 1s for that slot.
- Enable/reset mid-slot:
  - Stimulus: deassert enable (or assert reset) during the lit phase of slot 3.
  - Expected: anode_n = all 1s at the next edge. Re-enabling restarts at digit_index 0 with a new snapshot and a frame_start pulse.

Source files
------------

// File: rtl/display_scan_mux.sv
// Six-digit (parameterizable) multiplexed scan driver for a shared-segment display.
// Each slot is a dark dead time followed by a lit window; digits are snapshotted once per frame.

module display_scan_mux_slot #(
    parameter bit IS_MSD = 1'b0
) (
    input  logic [3:0] value,
    input  logic       blink_en,
    input  logic       blink_phase,
    input  logic       lz_blank,
    output logic       suppress
);
    // Codes above 9 have no decoder entry, so they are kept dark rather than shown as garbage.
    assign suppress = (blink_en && blink_phase)
                    || (IS_MSD && lz_blank && (value == 4'd0))
                    || (value > 4'd9);
endmodule

module display_scan_mux #(
    parameter int NUM_DIGITS   = 6,
    parameter int DWELL_CYCLES = 1000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    output logic [3:0]              digit_data,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [2:0]              digit_index,
    output logic                    frame_start
);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_ON
    } state_t;

    state_t                       state, state_nxt;
    logic [CW-1:0]                cnt, cnt_nxt;
    logic [FW-1:0]                frame_cnt, frame_cnt_nxt;
    logic                         blink_phase, blink_phase_nxt;
    logic [NUM_DIGITS-1:0][3:0]   shadow, shadow_nxt;
    logic [NUM_DIGITS-1:0][3:0]   digits_vec;
    logic [NUM_DIGITS-1:0]        suppress;
    logic [NUM_DIGITS-1:0]        anode_nxt;
    logic [2:0]                   idx_nxt, idx_inc;
    logic [3:0]                   data_nxt;
    logic                         frame_start_nxt;

    assign digits_vec = digits_in;
    assign idx_inc    = digit_index + 3'd1;

    // Suppression looks at the frozen snapshot but at the live blink/blank controls.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            display_scan_mux_slot #(
                .IS_MSD (gi == NUM_DIGITS - 1)
            ) u_slot (
                .value       (shadow[gi]),
                .blink_en    (blink_mask[gi]),
                .blink_phase (blink_phase),
                .lz_blank    (lz_blank),
                .suppress    (suppress[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow      <= '0;
            digit_index <= '0;
            digit_data  <= '0;
            anode_n     <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            frame_cnt   <= frame_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            shadow      <= shadow_nxt;
            digit_index <= idx_nxt;
            digit_data  <= data_nxt;
            anode_n     <= anode_nxt;
            frame_start <= frame_start_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        frame_cnt_nxt   = frame_cnt;
        blink_phase_nxt = blink_phase;
        shadow_nxt      = shadow;
        idx_nxt         = digit_index;
        data_nxt        = digit_data;
        frame_start_nxt = 1'b0;

        if (!enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    shadow_nxt      = digits_vec;
                    idx_nxt         = '0;
                    data_nxt        = digits_vec[0];
                    cnt_nxt         = '0;
                    frame_start_nxt = 1'b1;
                    state_nxt       = S_DEAD;
                end
                S_DEAD: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == DEAD_LAST)
                        state_nxt = S_ON;
                end
                S_ON: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = S_DEAD;
                        if (digit_index == IDX_LAST) begin
                            // Frame wrap: fresh snapshot and blink bookkeeping.
                            idx_nxt         = '0;
                            shadow_nxt      = digits_vec;
                            data_nxt        = digits_vec[0];
                            frame_start_nxt = 1'b1;
                            if (frame_cnt == FRAME_LAST) begin
                                frame_cnt_nxt   = '0;
                                blink_phase_nxt = ~blink_phase;
                            end else begin
                                frame_cnt_nxt = frame_cnt + 1'b1;
                            end
                        end else begin
                            idx_nxt  = idx_inc;
                            data_nxt = shadow[idx_inc];
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        // The index never changes on an edge that lands in S_ON, so the current one is the lit one.
        anode_nxt = '1;
        if (state_nxt == S_ON && !suppress[digit_index])
            anode_nxt[digit_index] = 1'b0;
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with short slots so whole frames are checked cycle by cycle.

module tb_display_scan_mux;
    localparam int ND    = 6;
    localparam int DWELL = 8;
    localparam int DEAD  = 2;
    localparam int BLINK = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [23:0]   digits_in;
    logic [5:0]    blink_mask;
    logic          lz_blank;
    logic [3:0]    digit_data;
    logic [5:0]    anode_n;
    logic [2:0]    digit_index;
    logic          frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    display_scan_mux #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DWELL),
        .DEAD_CYCLES  (DEAD),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digits_in   (digits_in),
        .blink_mask  (blink_mask),
        .lz_blank    (lz_blank),
        .digit_data  (digit_data),
        .anode_n     (anode_n),
        .digit_index (digit_index),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk one full frame from slot 0 / cycle 0; optionally change digits_in mid slot chg_slot.
    task automatic check_frame(input string tag, input logic [23:0] expd, input logic [5:0] lit,
                               input int chg_slot, input logic [23:0] chg_val);
        logic [5:0] on_pat;
        for (int s = 0; s < ND; s++) begin
            for (int c = 0; c < DWELL; c++) begin
                on_pat = 6'h3F;
                if (c >= DEAD && lit[s]) on_pat[s] = 1'b0;
                chk({tag, ".anode"}, 32'(anode_n), 32'(on_pat));
                chk({tag, ".data"},  32'(digit_data), 32'(expd[4*s +: 4]));
                chk({tag, ".index"}, 32'(digit_index), 32'(s));
                chk({tag, ".fstart"}, 32'(frame_start), 32'(s == 0 && c == 0));
                if (s == chg_slot && c == 4) digits_in = chg_val;
                tick();
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        digits_in  = 24'h000000;
        blink_mask = 6'b000000;
        lz_blank   = 1'b0;
        tick();
        tick();
        chk("rst.anode",  32'(anode_n), 32'h3F);
        chk("rst.data",   32'(digit_data), 32'h0);
        chk("rst.index",  32'(digit_index), 32'h0);
        chk("rst.fstart", 32'(frame_start), 32'h0);

        // Basic scan, then a mid-frame change that must wait for the next snapshot.
        reset     = 1'b0;
        enable    = 1'b1;
        digits_in = 24'h123456;
        tick();
        check_frame("f0", 24'h123456, 6'h3F, -1, 24'h0);
        check_frame("f1_snap", 24'h123456, 6'h3F, 2, 24'h999999);

        // Blink: phase goes high after two frames, low again after two more.
        blink_mask = 6'b110000;
        check_frame("f2_blink", 24'h999999, 6'h0F, -1, 24'h0);
        check_frame("f3_blink", 24'h999999, 6'h0F, -1, 24'h0);
        check_frame("f4_blink", 24'h999999, 6'h3F, 2, 24'h052000);

        // Leading-zero blanking of the hours-tens digit.
        blink_mask = 6'b000000;
        lz_blank   = 1'b1;
        check_frame("f5_lz1", 24'h052000, 6'h1F, -1, 24'h0);
        lz_blank = 1'b0;
        check_frame("f6_lz0", 24'h052000, 6'h3F, 2, 24'h052A00);

        // Invalid BCD in digit 2 stays dark but its value still reaches the decoder.
        check_frame("f7_bad", 24'h052A00, 6'h3B, -1, 24'h0);

        // Drop enable in the lit window of slot 3.
        for (int i = 0; i < 3 * DWELL + 3; i++) tick();
        chk("en.lit", 32'(anode_n), 32'h37);
        enable = 1'b0;
        tick();
        chk("en.off.anode", 32'(anode_n), 32'h3F);
        chk("en.off.index", 32'(digit_index), 32'h0);
        tick();
        chk("en.idle.anode", 32'(anode_n), 32'h3F);
        chk("en.idle.fstart", 32'(frame_start), 32'h0);
        digits_in = 24'h123456;
        enable    = 1'b1;
        tick();
        check_frame("f_reen", 24'h123456, 6'h3F, -1, 24'h0);

        // Reset in the lit window of slot 3, with enable held high.
        for (int i = 0; i < 3 * DWELL + 3; i++) tick();
        chk("rst2.lit", 32'(anode_n), 32'h37);
        reset = 1'b1;
        tick();
        chk("rst2.anode",  32'(anode_n), 32'h3F);
        chk("rst2.data",   32'(digit_data), 32'h0);
        chk("rst2.index",  32'(digit_index), 32'h0);
        chk("rst2.fstart", 32'(frame_start), 32'h0);
        reset     = 1'b0;
        digits_in = 24'h654321;
        tick();
        chk("rst2.rs.fstart", 32'(frame_start), 32'h1);
        chk("rst2.rs.data",   32'(digit_data), 32'h1);
        check_frame("f_rst", 24'h654321, 6'h3F, -1, 24'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
